// File: rtl/bcd3_down_counter.sv
// Three-digit BCD down counter with IDLE/RUN/EXPIRED control and optional reload.
// Define BCD_DOWN_SAT_EN to saturate at 000 (and expire) on a terminal event.
module bcd3_down_counter #(
  parameter int AUTO_RELOAD = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [11:0] load_val,
  input  logic        start,
  input  logic        stop,
  input  logic        tick,
  output logic [11:0] count,
  output logic        zero,
  output logic        busy,
  output logic        expired,
  output logic        borrow,
  output logic        load_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_EXPIRED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] count_q, count_d;
  logic [11:0] reload_q, reload_d;
  logic        borrow_q, borrow_d;
  logic        load_err_q, load_err_d;

  function automatic logic bcd_valid(input logic [11:0] v);
    return (v[11:8] <= 4'd9) && (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Caller guarantees v != 000, so the hundreds digit never underflows.
  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [3:0] h, t, u;
    h = v[11:8];
    t = v[7:4];
    u = v[3:0];
    if (u != 4'd0) begin
      u = u - 4'd1;
    end else begin
      u = 4'd9;
      if (t != 4'd0) begin
        t = t - 4'd1;
      end else begin
        t = 4'd9;
        h = h - 4'd1;
      end
    end
    return {h, t, u};
  endfunction

  // Next-state logic; priority is load > stop > start > tick.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    reload_d   = reload_q;
    borrow_d   = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (bcd_valid(load_val)) begin
        count_d  = load_val;
        reload_d = load_val;
        state_d  = S_IDLE;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (stop) begin
      state_d = S_IDLE;
    end else if (start && (state_q != S_RUN)) begin
      state_d = S_RUN;
    end else if (tick && (state_q == S_RUN)) begin
      if (count_q != 12'h000) begin
        count_d = bcd_dec(count_q);
      end else begin
        borrow_d = 1'b1;
`ifdef BCD_DOWN_SAT_EN
        count_d = 12'h000;
        state_d = S_EXPIRED;
`else
        if (AUTO_RELOAD != 0) begin
          count_d = reload_q;
        end else begin
          count_d = 12'h999;
          state_d = S_EXPIRED;
        end
`endif
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      count_q    <= 12'h000;
      reload_q   <= 12'h000;
      borrow_q   <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      reload_q   <= reload_d;
      borrow_q   <= borrow_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign zero     = (count_q == 12'h000);
  assign busy     = (state_q == S_RUN);
  assign expired  = (state_q == S_EXPIRED);
  assign borrow   = borrow_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd3_down_counter.sv
// Directed bench: two instances (AUTO_RELOAD 0 and 1) share stimulus; table rows
// plus hand-written reset sequences. Honors BCD_DOWN_SAT_EN for expectations.
module tb_bcd3_down_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [11:0] load_val = 12'h000;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        tick = 1'b0;

  logic [11:0] a_count, b_count;
  logic        a_zero, a_busy, a_expired, a_borrow, a_load_err;
  logic        b_zero, b_busy, b_expired, b_borrow, b_load_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd3_down_counter #(.AUTO_RELOAD(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .tick(tick),
    .count(a_count), .zero(a_zero), .busy(a_busy), .expired(a_expired),
    .borrow(a_borrow), .load_err(a_load_err)
  );

  bcd3_down_counter #(.AUTO_RELOAD(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val),
    .start(start), .stop(stop), .tick(tick),
    .count(b_count), .zero(b_zero), .busy(b_busy), .expired(b_expired),
    .borrow(b_borrow), .load_err(b_load_err)
  );

  typedef struct {
    logic        ld;
    logic [11:0] lv;
    logic        st;
    logic        sp;
    logic        tk;
    logic [11:0] a_cnt;
    logic        a_busy;
    logic        a_exp;
    logic        a_brw;
    logic [11:0] b_cnt;
    logic        b_busy;
    logic        b_exp;
    logic        b_brw;
    logic        lerr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ld, input logic [11:0] lv, input logic st,
                              input logic sp, input logic tk,
                              input logic [11:0] ac, input logic ab, input logic ae, input logic abr,
                              input logic [11:0] bc, input logic bb, input logic be, input logic bbr,
                              input logic le);
    vec_t v;
    v.ld = ld; v.lv = lv; v.st = st; v.sp = sp; v.tk = tk;
    v.a_cnt = ac; v.a_busy = ab; v.a_exp = ae; v.a_brw = abr;
    v.b_cnt = bc; v.b_busy = bb; v.b_exp = be; v.b_brw = bbr;
    v.lerr = le;
    return v;
  endfunction

  function automatic vec_t mk2(input logic ld, input logic [11:0] lv, input logic st,
                               input logic sp, input logic tk, input logic [11:0] c,
                               input logic bz, input logic ex, input logic br, input logic le);
    return mk(ld, lv, st, sp, tk, c, bz, ex, br, c, bz, ex, br, le);
  endfunction

  task automatic check_outputs(input string tag, input logic [11:0] ac, input logic ab,
                               input logic ae, input logic abr, input logic [11:0] bc,
                               input logic bb, input logic be, input logic bbr, input logic le);
    chk({tag, " a_count"},    a_count,    ac);
    chk({tag, " a_zero"},     a_zero,     12'(ac == 12'h000));
    chk({tag, " a_busy"},     a_busy,     ab);
    chk({tag, " a_expired"},  a_expired,  ae);
    chk({tag, " a_borrow"},   a_borrow,   abr);
    chk({tag, " a_load_err"}, a_load_err, le);
    chk({tag, " b_count"},    b_count,    bc);
    chk({tag, " b_zero"},     b_zero,     12'(bc == 12'h000));
    chk({tag, " b_busy"},     b_busy,     bb);
    chk({tag, " b_expired"},  b_expired,  be);
    chk({tag, " b_borrow"},   b_borrow,   bbr);
    chk({tag, " b_load_err"}, b_load_err, le);
  endtask

  initial begin
    //            ld  lv      st   sp   tk   count  busy exp  brw  lerr
    vecs.push_back(mk2(1'b1, 12'h102, 1'b0, 1'b0, 1'b0, 12'h102, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk2(1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'h102, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk2(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'h101, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk2(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'h100, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk2(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'h099, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk2(1'b1, 12'h001, 1'b0, 1'b0, 1'b0, 12'h001, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk2(1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'h001, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk2(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0));
`ifdef BCD_DOWN_SAT_EN
    vecs.push_back(mk2(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk2(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk2(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk2(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0));
`else
    vecs.push_back(mk(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'h999, 1'b0, 1'b1, 1'b1, 12'h001, 1'b1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'h999, 1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'h999, 1'b0, 1'b1, 1'b0, 12'h001, 1'b1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h999, 1'b0, 1'b1, 1'b0, 12'h001, 1'b1, 1'b0, 1'b0, 1'b0));
`endif
    vecs.push_back(mk2(1'b1, 12'h002, 1'b0, 1'b0, 1'b0, 12'h002, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk2(1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'h002, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk2(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'h001, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk2(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0));
`ifdef BCD_DOWN_SAT_EN
    vecs.push_back(mk2(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk2(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk2(1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk2(1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk2(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 1'b1, 1'b1, 1'b0));
`else
    vecs.push_back(mk(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'h999, 1'b0, 1'b1, 1'b1, 12'h002, 1'b1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'h999, 1'b0, 1'b1, 1'b0, 12'h001, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 12'h000, 1'b0, 1'b1, 1'b0, 12'h999, 1'b0, 1'b0, 1'b0, 12'h001, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'h999, 1'b1, 1'b0, 1'b0, 12'h001, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'h998, 1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0));
`endif
    vecs.push_back(mk2(1'b1, 12'h050, 1'b0, 1'b0, 1'b0, 12'h050, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk2(1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'h050, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk2(1'b1, 12'h1A5, 1'b0, 1'b0, 1'b0, 12'h050, 1'b1, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk2(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h050, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk2(1'b1, 12'h123, 1'b1, 1'b0, 1'b0, 12'h123, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk2(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h123, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk2(1'b0, 12'h000, 1'b1, 1'b0, 1'b0, 12'h123, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk2(1'b0, 12'h000, 1'b0, 1'b1, 1'b1, 12'h123, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk2(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'h123, 1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk2(1'b0, 12'h000, 1'b1, 1'b0, 1'b1, 12'h123, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk2(1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 12'h122, 1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk2(1'b1, 12'h09F, 1'b0, 1'b0, 1'b0, 12'h122, 1'b1, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk2(1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 12'h122, 1'b1, 1'b0, 1'b0, 1'b0));

    // Reset state, checked while rst_n is still low.
    #2;
    check_outputs("reset", 12'h000, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      load = vecs[i].ld; load_val = vecs[i].lv;
      start = vecs[i].st; stop = vecs[i].sp; tick = vecs[i].tk;
      @(negedge clk);
      check_outputs($sformatf("row%0d", i), vecs[i].a_cnt, vecs[i].a_busy, vecs[i].a_exp,
                    vecs[i].a_brw, vecs[i].b_cnt, vecs[i].b_busy, vecs[i].b_exp,
                    vecs[i].b_brw, vecs[i].lerr);
    end

    // Asynchronous reset in the middle of a RUN at count 437.
    load = 1'b1; load_val = 12'h437; start = 1'b0; stop = 1'b0; tick = 1'b0;
    @(negedge clk);
    load = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_outputs("pre_rst", 12'h437, 1'b1, 1'b0, 1'b0, 12'h437, 1'b1, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_outputs("async_rst", 12'h000, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check_outputs("post_rst_tick", 12'h000, 1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd3_down_counter.md
BCD3_DOWN_COUNTER -- requirements
Module: bcd3_down_counter

Interface
REQ-001 Parameter: AUTO_RELOAD, default 0, 1 = reload the last accepted load value on a terminal event, 0 = wrap to 999 and expire.
REQ-002 Port: clk  in  1  single clock, all state updates on rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 Port: load  in  1  request to load load_val; sampled each cycle.
REQ-005 Port: load_val  in  12  three packed BCD digits [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-006 Port: start  in  1  begin or resume counting.
REQ-007 Port: stop  in  1  halt counting and return to IDLE.
REQ-008 Port: tick  in  1  decrement strobe; acts only in RUN.
REQ-009 Port: count  out  12  current BCD value, registered.
REQ-010 Port: zero  out  1  combinational, high when count==12'h000.
REQ-011 Port: busy  out  1  high in RUN.
REQ-012 Port: expired  out  1  high in EXPIRED.
REQ-013 Port: borrow  out  1  registered one-cycle pulse on each terminal event.
REQ-014 Port: load_err  out  1  registered one-cycle pulse when a load is rejected.

Function
REQ-015 FSM states: IDLE, RUN, EXPIRED; encoding free.
REQ-016 Per-cycle input priority: load > stop > start > tick.
REQ-017 Load is valid only when every nibble of load_val is <= 9; a valid load sets count and reload_reg to load_val and forces IDLE in the next cycle, from any state.
REQ-018 An invalid load leaves count, reload_reg and state unchanged and pulses load_err the next cycle.
REQ-019 stop in RUN or EXPIRED goes to IDLE; count is held.
REQ-020 start in IDLE or EXPIRED goes to RUN next cycle; count is unchanged on that edge, and a tick on the same cycle is ignored.
REQ-021 In RUN, tick with count!=000 decrements by one in BCD: the units digit 0 becomes 9 with a borrow into tens, and tens 0 becomes 9 with a borrow into hundreds; single-cycle latency.
REQ-022 Terminal event: tick in RUN while count==000; borrow pulses high on the following cycle.
REQ-023 Terminal with AUTO_RELOAD=1: count <= reload_reg, state stays RUN.
REQ-024 Terminal with AUTO_RELOAD=0: count <= 12'h999, state goes to EXPIRED.
REQ-025 In IDLE and EXPIRED, tick has no effect; count holds.
REQ-026 count never holds a non-BCD nibble.
REQ-027 borrow and load_err are never high for two consecutive cycles from a single event.

Reset
REQ-028 While rst_n is low, the block is held in reset: count=000, reload_reg=000, state=IDLE, busy=0, expired=0, borrow=0, load_err=0, zero=1.
REQ-029 Reset during RUN aborts immediately; the first post-reset edge behaves as IDLE.

Configuration
REQ-030 Macro BCD_DOWN_SAT_EN: when defined, the terminal event holds count at 000 and enters EXPIRED regardless of AUTO_RELOAD, with borrow still pulsing; when undefined, REQ-023/REQ-024 apply.

Verification
REQ-031 Reset, load 12'h102, start, 3 ticks -> count 101, 100, 099; busy=1.
REQ-032 AUTO_RELOAD=0, load 12'h001, start, 2 ticks -> count 000 (zero=1), then 999, borrow pulse 1 cycle, expired=1; further ticks -> no change.
REQ-033 AUTO_RELOAD=1, load 12'h002, start, 4 ticks -> count 001, 000, 002 with borrow pulse, then 001; busy stays 1.
REQ-034 Load 12'h1A5 while count=050 -> load_err pulse, count stays 050, state unchanged; load+start same cycle -> IDLE, start ignored.
REQ-035 rst_n low mid-RUN at count 437 -> count=000 and busy=0 immediately, without waiting for a clock edge; with BCD_DOWN_SAT_EN, count=000 plus tick -> count stays 000, expired=1, borrow pulse.
